// File: rtl/obi_slow_mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_slow_mem_pkg : response-entry type and byte-enable merge helper        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package obi_slow_mem_pkg;

   // Countdown width is fixed so the type can live here; covers RVALID_DELAY up to 256.
   localparam int CNT_W = 8;

   typedef struct packed {
      logic [31:0]      rdata;
      logic [CNT_W-1:0] cnt;
   } resp_entry_t;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old_word,
      input logic [31:0] new_word,
      input logic [3:0]  be
   );
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            res[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/obi_slow_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_slow_mem_if : OBI request/response bundle with master and slave views  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface obi_slow_mem_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface
`default_nettype wire

// File: rtl/obi_slow_mem_resp_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_slow_mem_resp_queue : in-order circular buffer of delayed responses    |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module obi_slow_mem_resp_queue
   import obi_slow_mem_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        push,
   input  resp_entry_t push_entry,
   output logic        pop,
   output resp_entry_t head,
   output logic        full
);

   localparam int                PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int                CNT_QW = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0]  LAST   = PTR_W'(DEPTH - 1);
   localparam logic [CNT_QW-1:0] CAP    = CNT_QW'(DEPTH);

   resp_entry_t       entries [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_QW-1:0] count;

   assign head = entries[rd_ptr];
   assign pop  = vld[rd_ptr] && (head.cnt == '0);
   assign full = (count == CAP);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= (rd_ptr == LAST) ? '0 : rd_ptr + PTR_W'(1);
         end
         // When full, wr_ptr == rd_ptr: the push must win over the pop's clear.
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_QW'(1);
            2'b01:   count <= count - CNT_QW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && (entries[i].cnt != '0)) begin
            entries[i].cnt <= entries[i].cnt - CNT_W'(1);
         end
      end
      if (push) begin
         entries[wr_ptr] <= push_entry;
      end
   end

endmodule
`default_nettype wire

// File: rtl/obi_slow_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obi_slow_mem : OBI slave memory with programmable grant and rvalid latency |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module obi_slow_mem
   import obi_slow_mem_pkg::*;
#(
   parameter int NUM_WORDS       = 1024,
   parameter int GNT_DELAY       = 2,
   parameter int RVALID_DELAY    = 3,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   obi_slow_mem_if.slave bus
);

   localparam int                IDX_W    = $clog2(NUM_WORDS);
   localparam int                WAIT_W   = (GNT_DELAY > 0) ? $clog2(GNT_DELAY + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(GNT_DELAY);
   localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(RVALID_DELAY - 1);

   logic [31:0]       mem_q [NUM_WORDS];
   logic [WAIT_W-1:0] wait_q;
   logic [IDX_W-1:0]  word_idx;
   logic [31:0]       rd_word;
   logic              wait_done;
   logic              slot_free;
   logic              gnt;
   logic              pop;
   logic              full;
   resp_entry_t       push_entry;
   resp_entry_t       head;
   logic              unused_addr;

   // Upper address bits alias onto the array; byte offset is ignored.
   assign word_idx    = bus.addr[IDX_W+1:2];
   assign unused_addr = ^{bus.addr[31:IDX_W+2], bus.addr[1:0]};
   assign rd_word     = mem_q[word_idx];

   assign wait_done = (wait_q == WAIT_MAX);
   assign slot_free = !full || pop;
   assign gnt       = bus.req && wait_done && slot_free && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_q <= '0;
      end else if (!bus.req || gnt) begin
         wait_q <= '0;
      end else if (!wait_done) begin
         wait_q <= wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (gnt && bus.we) begin
         mem_q[word_idx] <= be_merge(rd_word, bus.wdata, bus.be);
      end
   end

   always_comb begin
      push_entry.rdata = bus.we ? 32'h0 : rd_word;
      push_entry.cnt   = CNT_INIT;
   end

   obi_slow_mem_resp_queue #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_resp_queue (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push       (gnt),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (full)
   );

   assign bus.gnt    = gnt;
   assign bus.rvalid = pop;
   assign bus.rdata  = pop ? head.rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_obi_slow_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_obi_slow_mem : scoreboard bench over four latency configurations        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_obi_slow_mem;

   localparam int ND = 4;

   logic        clk = 1'b0;
   int          cyc = 0;
   logic        rst    [ND];
   logic        req    [ND];
   logic        we     [ND];
   logic [3:0]  be     [ND];
   logic [31:0] addr   [ND];
   logic [31:0] wdata  [ND];
   logic        gnt    [ND];
   logic        rvalid [ND];
   logic [31:0] rdata  [ND];

   logic [63:0] expq [ND][$];
   int          rvcnt [ND];
   int          checks = 0;
   int          errors = 0;
   logic [63:0] mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   obi_slow_mem_if bus [ND] ();

   // 0: defaults, 1: fast grant, 2: shallow queue, 3: long read latency
   for (genvar i = 0; i < ND; i++) begin : g_dut
      localparam int GD = (i == 0) ? 2 : (i == 3) ? 1 : 0;
      localparam int RD = (i == 2) ? 6 : (i == 3) ? 8 : 3;
      localparam int MO = (i == 2) ? 2 : 4;

      assign bus[i].req   = req[i];
      assign bus[i].we    = we[i];
      assign bus[i].be    = be[i];
      assign bus[i].addr  = addr[i];
      assign bus[i].wdata = wdata[i];
      assign gnt[i]       = bus[i].gnt;
      assign rvalid[i]    = bus[i].rvalid;
      assign rdata[i]     = bus[i].rdata;

      obi_slow_mem #(
         .NUM_WORDS       (1024),
         .GNT_DELAY       (GD),
         .RVALID_DELAY    (RD),
         .MAX_OUTSTANDING (MO)
      ) dut (
         .clk_i (clk),
         .rst_i (rst[i]),
         .bus   (bus[i])
      );
   end

   function automatic int rvd(input int d);
      case (d)
         2:       return 6;
         3:       return 8;
         default: return 3;
      endcase
   endfunction

   task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", nm, d, act, exp, cyc);
      end
   endtask

   // Monitor: every response is matched against the oldest expectation.
   always @(negedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (!rst[d] && rvalid[d]) begin
            rvcnt[d]++;
            if (expq[d].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rvalid dut%0d: got rdata %h with no pending request (cycle %0d)",
                        d, rdata[d], cyc);
            end else begin
               mon_e = expq[d].pop_front();
               check("rdata", d, rdata[d], mon_e[31:0]);
               check("rvalid_cycle", d, 32'(cyc), mon_e[63:32]);
            end
         end
      end
   end

   // Called at a falling edge; returns at the falling edge after the grant cycle.
   task automatic xfer(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp, input int exp_wait);
      int waited;
      bit got;
      waited = 0;
      got    = 1'b0;
      req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
      while (!got && waited < 60) begin
         #1;
         if (gnt[d]) begin
            got = 1'b1;
         end else begin
            @(negedge clk);
            waited++;
         end
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL gnt_timeout dut%0d: got no grant expected one within 60 cycles (addr %h)", d, a);
      end else begin
         expq[d].push_back({32'(cyc + rvd(d)), exp});
         if (exp_wait >= 0) check("gnt_wait", d, 32'(waited), 32'(exp_wait));
      end
      @(negedge clk);
      req[d] = 1'b0;
   endtask

   task automatic drain(input int d);
      int n;
      n = 0;
      while (expq[d].size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (expq[d].size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain dut%0d: got %0d responses outstanding expected 0", d, expq[d].size());
      end
      @(negedge clk);
   endtask

   initial begin
      int base;
      for (int d = 0; d < ND; d++) begin
         rst[d] = 1'b1; req[d] = 1'b0; we[d] = 1'b0; be[d] = 4'h0;
         addr[d] = 32'h0; wdata[d] = 32'h0; rvcnt[d] = 0;
      end
      repeat (3) @(negedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         check("reset_gnt", d, {31'h0, gnt[d]}, 32'h0);
         check("reset_rvalid", d, {31'h0, rvalid[d]}, 32'h0);
         check("reset_rdata", d, rdata[d], 32'h0);
      end
      @(negedge clk);
      for (int d = 0; d < ND; d++) rst[d] = 1'b0;
      @(negedge clk);

      // Defaults: write/read, partial byte enables, be=0, aliasing.
      xfer(0, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        2);
      xfer(0, 1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 2);
      xfer(0, 1'b1, 4'hF, 32'h80,   32'h11223344, 32'h0,        2);
      xfer(0, 1'b1, 4'h5, 32'h80,   32'hAABBCCDD, 32'h0,        2);
      xfer(0, 1'b0, 4'hF, 32'h80,   32'h0,        32'h11BB33DD, 2);
      xfer(0, 1'b1, 4'h0, 32'h10,   32'hFFFFFFFF, 32'h0,        2);
      xfer(0, 1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 2);
      xfer(0, 1'b1, 4'hF, 32'h1000, 32'h5,        32'h0,        2);
      xfer(0, 1'b0, 4'hF, 32'h0,    32'h0,        32'h5,        2);
      xfer(0, 1'b0, 4'hF, 32'h3,    32'h0,        32'h5,        2);

      // Zero grant delay: full-rate writes then full-rate reads, then read-after-write.
      for (int i = 0; i < 8; i++) xfer(1, 1'b1, 4'hF, 32'(4*i), 32'hC0DE0000 | 32'(i), 32'h0, 0);
      for (int i = 0; i < 8; i++) xfer(1, 1'b0, 4'hF, 32'(4*i), 32'h0, 32'hC0DE0000 | 32'(i), 0);
      xfer(1, 1'b1, 4'hF, 32'h40, 32'h12345678, 32'h0,        0);
      xfer(1, 1'b0, 4'hF, 32'h40, 32'h0,        32'h12345678, 0);

      // Shallow queue: grant stalls while full and returns in the pop cycle.
      for (int i = 0; i < 5; i++) xfer(2, 1'b1, 4'hF, 32'(4*i), 32'h5A000000 + 32'(i), 32'h0, -1);
      drain(2);
      xfer(2, 1'b0, 4'hF, 32'h0,  32'h0, 32'h5A000000, 0);
      xfer(2, 1'b0, 4'hF, 32'h4,  32'h0, 32'h5A000001, 0);
      xfer(2, 1'b0, 4'hF, 32'h8,  32'h0, 32'h5A000002, 4);
      xfer(2, 1'b0, 4'hF, 32'hC,  32'h0, 32'h5A000003, 0);
      xfer(2, 1'b0, 4'hF, 32'h10, 32'h0, 32'h5A000004, 4);

      // Reset with three reads in flight: their responses must vanish.
      xfer(3, 1'b1, 4'hF, 32'h0C, 32'h0BADF00D, 32'h0, 1);
      xfer(3, 1'b1, 4'hF, 32'h10, 32'h600DCAFE, 32'h0, 1);
      drain(3);
      xfer(3, 1'b0, 4'hF, 32'h0C, 32'h0, 32'h0BADF00D, 1);
      xfer(3, 1'b0, 4'hF, 32'h10, 32'h0, 32'h600DCAFE, 1);
      xfer(3, 1'b0, 4'hF, 32'h0C, 32'h0, 32'h0BADF00D, 1);
      rst[3] = 1'b1;
      expq[3].delete();
      @(negedge clk);
      rst[3] = 1'b0;
      base = rvcnt[3];
      repeat (10) @(negedge clk);
      check("rst_quiet_rvalids", 3, 32'(rvcnt[3] - base), 32'h0);
      xfer(3, 1'b0, 4'hF, 32'h10, 32'h0, 32'h600DCAFE, 1);

      for (int d = 0; d < ND; d++) drain(d);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
